traffic_request_gen: RTL and testbench
======================================

// Module: traffic_request_gen
// PURPOSE
//  Request front-end for the traffic-light controller. Synchronises and debounces the raw
//  pedestrian push-button and the 8 per-lane siren detectors. Arbitrates between them and
//  drives the controller's pedSignal, emgSignal and emgLane request inputs.
//  Holds each request until the controller reports service done via svc_done.
//  Sits between field sensors and the TrafficMode / Emergency / Pedestrian logic.
// PARAMETERS
//  DEBOUNCE_CYC  3   consecutive stable cycles before a synchronised input changes level (1..15)
//  EMG_MIN_HOLD  10  minimum cycles emgSignal stays high once granted (1..127)
// PORTS
//  clk          in   1      system clock (1 s tick)
//  rst          in   1      asynchronous, active-low reset
//  ped_btn_raw  in   1      raw pedestrian push-button, asynchronous
//  emg_req_raw  in   8      raw siren detector per lane, bit i = lane i, asynchronous
//  svc_done     in   1      1-cycle pulse from controller: current mode's timer reached zero
//  pedSignal    out  1      pedestrian crossing request to controller
//  emgSignal    out  1      emergency request to controller
//  emgLane      out  8      one-hot granted emergency lane; all zero when emgSignal=0
//  pedWaitTime  out  7      cycles the pending pedestrian request has waited, saturating
// BEHAVIOUR
//  Reset (rst=0, async):
//   - All outputs 0, state IDLE, ped_pending 0.
//   - Sync flops, debounce counters and debounced levels all 0.
//  Input conditioning:
//   - Each of the 9 raw inputs passes through a 2-flop synchroniser, then a per-input
//     debounce counter.
//   - The debounced level flips only after DEBOUNCE_CYC consecutive cycles of the new
//     synchronised value. Any mismatch clears the counter.
//   - Pulses shorter than DEBOUNCE_CYC cycles are ignored. Both edges are debounced
//     symmetrically.
//   - Latency: raw first sampled high at edge 0 -> debounced high after edge DEBOUNCE_CYC+1
//     -> registered outputs after edge DEBOUNCE_CYC+2.
//  ped_pending:
//   - Set on the rising edge of the debounced button, in any state.
//   - Cleared only by svc_done while in PED. A press while already pending has no effect.
//  pedWaitTime:
//   - +1 per cycle while ped_pending=1, saturates at 127.
//   - Returns to 0 in the cycle ped_pending clears.
//  FSM, all outputs registered:
//   - IDLE: pedSignal=0, emgSignal=0, emgLane=0.
//       - Any debounced emg bit set -> EMG. Latch the lowest-index set lane one-hot into
//         emgLane and load hold=EMG_MIN_HOLD.
//       - Otherwise, if ped_pending -> PED.
//   - EMG: emgSignal=1, emgLane frozen.
//       - hold decrements to 0 and saturates.
//       - Exit to IDLE when hold==0 and the latched lane's debounced bit is 0.
//       - Other lanes' requests are ignored while in EMG.
//       - svc_done is ignored in EMG.
//   - PED: pedSignal=1.
//       - svc_done=1 -> IDLE and clear ped_pending.
//       - Any debounced emg bit -> EMG (preemption). ped_pending is retained and pedSignal
//         drops in the same cycle.
//       - If emg and svc_done occur in the same cycle, EMG wins and ped_pending stays set.
//  Back-to-back emergencies:
//   - IDLE always sits between two EMG grants, so emgSignal is low for exactly 1 cycle.
//   - The controller sees a fresh rising edge and a new emgLane.
//  Outputs are mutually exclusive: pedSignal & emgSignal is never 1.
//  Reset mid-operation: outputs clear immediately (async), and the pending request is lost.
// TESTING
//  1. Reset, ped_btn_raw high for 2 cycles only (DEBOUNCE_CYC=3) -> pedSignal stays 0 and
//     pedWaitTime stays 0.
//  2. ped_btn_raw high 5 cycles -> pedSignal=1 at edge 5. pedWaitTime counts from 1.
//     svc_done pulse -> next edge pedSignal=0 and pedWaitTime=0.
//  3. emg_req_raw=8'b0010_0100 held for 20 cycles -> emgSignal=1 and emgLane=8'h04 at edge 5.
//     Release -> emgSignal drops once hold==0 and the debounced bit is 0.
//     Lane 5 still requesting -> IDLE 1 cycle, then emgLane=8'h20.
//  4. Pedestrian in PED, then emg_req_raw=8'h01 -> pedSignal=0 and emgSignal=1 on the same
//     edge, ped_pending kept. After the emergency clears, PED re-entered with pedWaitTime
//     still counting.
//  5. emg_req_raw=8'h80 for 4 cycles (EMG_MIN_HOLD=10) -> emgSignal high exactly 10 cycles.
//  6. Ped pending 200 cycles -> pedWaitTime saturates at 127. Assert rst=0 mid-EMG ->
//     all outputs 0 asynchronously, FSM returns to IDLE.

Source files
------------

// File: rtl/traffic_request_gen.sv
// Request front-end for the traffic-light controller.
// Conditions the raw pedestrian button and the 8 siren detectors with a
// 2-flop synchroniser plus a debounce counter per input. The conditioned
// requests are arbitrated into registered pedSignal / emgSignal / emgLane
// outputs. A request is held until the controller reports svc_done.
module traffic_request_gen #(
  parameter int DEBOUNCE_CYC = 3,   // 1..15
  parameter int EMG_MIN_HOLD = 10   // 1..127
) (
  input  logic       clk,
  input  logic       rst,           // asynchronous, active low
  input  logic       ped_btn_raw,
  input  logic [7:0] emg_req_raw,
  input  logic       svc_done,
  output logic       pedSignal,
  output logic       emgSignal,
  output logic [7:0] emgLane,
  output logic [6:0] pedWaitTime
);

  localparam int NIN = 9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMG  = 2'd1;
  localparam logic [1:0] ST_PED  = 2'd2;

  // The counter flips the level on the edge where it has already seen
  // DEBOUNCE_CYC-1 matching cycles and the current one matches too.
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYC - 1);

  // The hold counter tracks the remaining grant cycles after the current one,
  // so emgSignal stays high for exactly EMG_MIN_HOLD cycles at minimum.
  localparam logic [6:0] HOLD_INIT = 7'(EMG_MIN_HOLD - 1);

  logic [NIN-1:0] raw_vec;
  logic [NIN-1:0] db_lvl;
  logic           ped_db_d;

  assign raw_vec = {emg_req_raw, ped_btn_raw};

  // Per-input synchroniser and debouncer. Bit 0 is the button, bits 8:1 the lanes.
  genvar gi;
  generate
    for (gi = 0; gi < NIN; gi++) begin : g_cond
      logic       sync1_q, sync2_q;
      logic [3:0] cnt_q, cnt_d;
      logic       lvl_q, lvl_d;

      // Count consecutive cycles that disagree with the current level.
      always_comb begin
        cnt_d = 4'd0;
        lvl_d = lvl_q;
        if (sync2_q != lvl_q) begin
          if (cnt_q == DB_LAST) begin
            lvl_d = sync2_q;
            cnt_d = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      // Synchroniser flops, debounce counter and debounced level.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          cnt_q   <= 4'd0;
          lvl_q   <= 1'b0;
        end else begin
          sync1_q <= raw_vec[gi];
          sync2_q <= sync1_q;
          cnt_q   <= cnt_d;
          lvl_q   <= lvl_d;
        end
      end

      assign db_lvl[gi] = lvl_q;

      // The button's next level is tapped so a press is registered on the
      // same edge that its debounced level rises.
      if (gi == 0) begin : g_ped_tap
        assign ped_db_d = lvl_d;
      end
    end
  endgenerate

  logic [7:0] emg_db;
  logic       emg_any;
  logic [7:0] emg_lowest;
  logic       ped_rise;

  assign emg_db     = db_lvl[8:1];
  assign emg_any    = |emg_db;
  assign emg_lowest = emg_db & (~emg_db + 8'd1);
  assign ped_rise   = ped_db_d & ~db_lvl[0];

  logic [1:0] state_q, state_d;
  logic [7:0] lane_q, lane_d;
  logic [6:0] hold_q, hold_d;
  logic       pend_q, pend_d;
  logic [6:0] wait_q, wait_d;
  logic       ped_sig_q, emg_sig_q;
  logic       ped_clr;

  // Arbitration FSM: emergencies pre-empt the pedestrian phase and IDLE
  // always separates two grants.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    hold_d  = hold_q;
    ped_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (emg_any) begin
          state_d = ST_EMG;
          lane_d  = emg_lowest;
          hold_d  = HOLD_INIT;
        end else if (pend_q) begin
          state_d = ST_PED;
        end
      end
      ST_EMG: begin
        if (hold_q != 7'd0) begin
          hold_d = hold_q - 7'd1;
        end
        if ((hold_q == 7'd0) && ((emg_db & lane_q) == 8'd0)) begin
          state_d = ST_IDLE;
          lane_d  = 8'd0;
        end
      end
      ST_PED: begin
        if (emg_any) begin
          state_d = ST_EMG;
          lane_d  = emg_lowest;
          hold_d  = HOLD_INIT;
        end else if (svc_done) begin
          state_d = ST_IDLE;
          ped_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        lane_d  = 8'd0;
        hold_d  = 7'd0;
      end
    endcase
  end

  // Pending pedestrian request and its saturating wait time.
  always_comb begin
    pend_d = (pend_q & ~ped_clr) | ped_rise;
    wait_d = 7'd0;
    if (pend_d && pend_q) begin
      wait_d = (wait_q == 7'd127) ? wait_q : wait_q + 7'd1;
    end
  end

  // State, request bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      lane_q    <= 8'd0;
      hold_q    <= 7'd0;
      pend_q    <= 1'b0;
      wait_q    <= 7'd0;
      ped_sig_q <= 1'b0;
      emg_sig_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      wait_q    <= wait_d;
      ped_sig_q <= (state_d == ST_PED);
      emg_sig_q <= (state_d == ST_EMG);
    end
  end

  assign pedSignal   = ped_sig_q;
  assign emgSignal   = emg_sig_q;
  assign emgLane     = lane_q;
  assign pedWaitTime = wait_q;

endmodule

// File: tb/tb_traffic_request_gen.sv
// Directed bench for traffic_request_gen with DEBOUNCE_CYC=3, EMG_MIN_HOLD=10.
// Edge numbering: edge 0 is the first rising clock edge that samples a
// newly driven raw value; outputs are sampled 1 time unit after each edge.
module tb_traffic_request_gen;

  logic       clk;
  logic       rst;
  logic       ped_btn_raw;
  logic [7:0] emg_req_raw;
  logic       svc_done;
  logic       pedSignal;
  logic       emgSignal;
  logic [7:0] emgLane;
  logic [6:0] pedWaitTime;

  int checks;
  int errors;
  int cyc;
  int high_cnt;

  traffic_request_gen #(
    .DEBOUNCE_CYC(3),
    .EMG_MIN_HOLD(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ped_btn_raw(ped_btn_raw),
    .emg_req_raw(emg_req_raw),
    .svc_done   (svc_done),
    .pedSignal  (pedSignal),
    .emgSignal  (emgSignal),
    .emgLane    (emgLane),
    .pedWaitTime(pedWaitTime)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    rst         = 1'b0;
    ped_btn_raw = 1'b0;
    emg_req_raw = 8'h00;
    svc_done    = 1'b0;
    #2;
    check("rst_ped", 32'(pedSignal), 32'd0);
    check("rst_emg", 32'(emgSignal), 32'd0);
    check("rst_lane", 32'(emgLane), 32'd0);
    check("rst_wait", 32'(pedWaitTime), 32'd0);
    #20;
    rst = 1'b1;
    idle(3);

    // 1: 2-cycle glitch on the button is filtered out
    cyc = -1;
    ped_btn_raw = 1'b1;
    while (cyc < 10) begin
      tick();
      if (cyc == 1) ped_btn_raw = 1'b0;
      if (cyc == 6 || cyc == 10) begin
        check("t1_ped", 32'(pedSignal), 32'd0);
        check("t1_wait", 32'(pedWaitTime), 32'd0);
      end
    end

    // 2: valid press, pedestrian grant, service done
    cyc = -1;
    ped_btn_raw = 1'b1;
    while (cyc < 7) begin
      tick();
      case (cyc)
        4: begin
          check("t2_ped_e4", 32'(pedSignal), 32'd0);
          ped_btn_raw = 1'b0;
        end
        5: begin
          check("t2_ped_e5", 32'(pedSignal), 32'd1);
          check("t2_wait_e5", 32'(pedWaitTime), 32'd1);
          check("t2_emg_e5", 32'(emgSignal), 32'd0);
        end
        6: begin
          check("t2_wait_e6", 32'(pedWaitTime), 32'd2);
          svc_done = 1'b1;
        end
        7: begin
          check("t2_ped_e7", 32'(pedSignal), 32'd0);
          check("t2_wait_e7", 32'(pedWaitTime), 32'd0);
          svc_done = 1'b0;
        end
        default: ;
      endcase
    end
    idle(12);

    // 3: two lanes, lowest granted, back-to-back grant to lane 5
    cyc = -1;
    emg_req_raw = 8'h24;
    while (cyc < 40) begin
      tick();
      case (cyc)
        4:  check("t3_emg_e4", 32'(emgSignal), 32'd0);
        5: begin
          check("t3_emg_e5", 32'(emgSignal), 32'd1);
          check("t3_lane_e5", 32'(emgLane), 32'h04);
        end
        19: emg_req_raw = 8'h20;
        24: check("t3_emg_e24", 32'(emgSignal), 32'd1);
        25: begin
          check("t3_emg_e25", 32'(emgSignal), 32'd0);
          check("t3_lane_e25", 32'(emgLane), 32'h00);
        end
        26: begin
          check("t3_emg_e26", 32'(emgSignal), 32'd1);
          check("t3_lane_e26", 32'(emgLane), 32'h20);
          emg_req_raw = 8'h00;
        end
        35: check("t3_emg_e35", 32'(emgSignal), 32'd1);
        36: check("t3_emg_e36", 32'(emgSignal), 32'd0);
        default: ;
      endcase
    end
    idle(12);

    // 4: emergency pre-empts PED (with coincident svc_done), PED resumes
    cyc = -1;
    ped_btn_raw = 1'b1;
    while (cyc < 24) begin
      tick();
      case (cyc)
        4:  ped_btn_raw = 1'b0;
        5:  check("t4_ped_e5", 32'(pedSignal), 32'd1);
        6:  emg_req_raw = 8'h01;
        10: emg_req_raw = 8'h00;
        11: begin
          check("t4_ped_e11", 32'(pedSignal), 32'd1);
          check("t4_wait_e11", 32'(pedWaitTime), 32'd7);
          svc_done = 1'b1;
        end
        12: begin
          check("t4_ped_e12", 32'(pedSignal), 32'd0);
          check("t4_emg_e12", 32'(emgSignal), 32'd1);
          check("t4_lane_e12", 32'(emgLane), 32'h01);
          check("t4_wait_e12", 32'(pedWaitTime), 32'd8);
          svc_done = 1'b0;
        end
        13: svc_done = 1'b1;
        14: begin
          check("t4_emg_e14", 32'(emgSignal), 32'd1);
          svc_done = 1'b0;
        end
        22: begin
          check("t4_emg_e22", 32'(emgSignal), 32'd0);
          check("t4_ped_e22", 32'(pedSignal), 32'd0);
          check("t4_wait_e22", 32'(pedWaitTime), 32'd18);
        end
        23: begin
          check("t4_ped_e23", 32'(pedSignal), 32'd1);
          check("t4_wait_e23", 32'(pedWaitTime), 32'd19);
          svc_done = 1'b1;
        end
        24: begin
          check("t4_ped_e24", 32'(pedSignal), 32'd0);
          check("t4_wait_e24", 32'(pedWaitTime), 32'd0);
          svc_done = 1'b0;
        end
        default: ;
      endcase
    end
    idle(12);

    // 5: short siren burst still gets the minimum hold of 10 cycles
    cyc = -1;
    high_cnt = 0;
    emg_req_raw = 8'h80;
    while (cyc < 24) begin
      tick();
      if (emgSignal) high_cnt++;
      if (cyc == 3) emg_req_raw = 8'h00;
      if (cyc == 5) check("t5_lane_e5", 32'(emgLane), 32'h80);
      if (cyc == 14) check("t5_emg_e14", 32'(emgSignal), 32'd1);
      if (cyc == 15) check("t5_emg_e15", 32'(emgSignal), 32'd0);
    end
    check("t5_high_cycles", 32'(high_cnt), 32'd10);
    idle(8);

    // 6: wait time saturation, then asynchronous reset mid-emergency
    cyc = -1;
    ped_btn_raw = 1'b1;
    while (cyc < 206) begin
      tick();
      case (cyc)
        4:   ped_btn_raw = 1'b0;
        130: check("t6_wait_e130", 32'(pedWaitTime), 32'd126);
        131: check("t6_wait_e131", 32'(pedWaitTime), 32'd127);
        200: begin
          check("t6_wait_e200", 32'(pedWaitTime), 32'd127);
          emg_req_raw = 8'h01;
        end
        206: begin
          check("t6_emg_e206", 32'(emgSignal), 32'd1);
          check("t6_ped_e206", 32'(pedSignal), 32'd0);
        end
        default: ;
      endcase
    end
    emg_req_raw = 8'h00;
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_emg", 32'(emgSignal), 32'd0);
    check("t6_rst_lane", 32'(emgLane), 32'h00);
    check("t6_rst_ped", 32'(pedSignal), 32'd0);
    check("t6_rst_wait", 32'(pedWaitTime), 32'd0);
    #3;
    rst = 1'b1;
    idle(10);
    check("t6_after_ped", 32'(pedSignal), 32'd0);
    check("t6_after_emg", 32'(emgSignal), 32'd0);
    check("t6_after_wait", 32'(pedWaitTime), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Mutual exclusion of the two request outputs, checked every cycle.
  always @(negedge clk) begin
    if (pedSignal && emgSignal) begin
      errors++;
      $display("FAIL excl: pedSignal=%0d emgSignal=%0d required not both 1", pedSignal, emgSignal);
    end
  end

endmodule
